// File: rtl/commit_pkg.sv
// Shared types for the commit buffer: the queued execute result, head
// classification and CSR write FSM states.
package commit_pkg;

  // Width of the data/address/PC fields carried in a queued entry.
  localparam int ENTRY_XLEN = 32;

  localparam logic [5:0] EXC_INVALID_INST = 6'd2;

  typedef struct packed {
    logic [4:0]            rd;
    logic [ENTRY_XLEN-1:0] rd_val;
    logic [ENTRY_XLEN-1:0] inst_pc;
    logic                  jump;
    logic [ENTRY_XLEN-1:0] jump_pc;
    logic                  exception;
    logic [5:0]            exc_num;
    logic [ENTRY_XLEN-1:0] exc_val;
    logic                  store;
    logic [ENTRY_XLEN-1:0] store_addr;
    logic [ENTRY_XLEN-1:0] store_val;
    logic [1:0]            store_size;
    logic                  csr_write;
    logic [11:0]           csr_addr;
    logic [ENTRY_XLEN-1:0] csr_wdata;
  } commit_entry_t;

  typedef enum logic [2:0] {
    KIND_NODATA,
    KIND_EXCEPTION,
    KIND_WAIT_FIFO,
    KIND_WAIT_CSRW,
    KIND_COMMIT
  } commit_kind_e;

  typedef enum logic [1:0] {
    CSR_IDLE,
    CSR_WRITE,
    CSR_BRESP,
    CSR_COMMIT
  } csr_state_e;

endpackage

// File: rtl/commit_csr_writer.sv
// CSR write sequencer for the head entry: issues the write, waits for the
// response, then holds one cycle in CSR_COMMIT while the head retires.
module commit_csr_writer
  import commit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] data,
  input  logic            csrbus_wready,
  input  logic [2:0]      csrbus_bresp,
  input  logic            csrbus_bvalid,
  output logic [11:0]     csrbus_waddr,
  output logic [XLEN-1:0] csrbus_wdata,
  output logic            csrbus_wvalid,
  output logic            csrbus_bready,
  output logic            done,
  output logic            resp_err
);

  csr_state_e state, state_next;
  logic [2:0] bresp_q;

  always_comb begin
    state_next = state;
    case (state)
      CSR_IDLE:   if (start) state_next = CSR_WRITE;
      CSR_WRITE:  if (csrbus_wready) state_next = CSR_BRESP;
      CSR_BRESP:  if (csrbus_bvalid) state_next = CSR_COMMIT;
      CSR_COMMIT: state_next = CSR_IDLE;
      default:    state_next = CSR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CSR_IDLE;
    else       state <= state_next;
  end

  // The response code is only meaningful once it has been accepted.
  always_ff @(posedge clk) begin
    if (state == CSR_BRESP && csrbus_bvalid) bresp_q <= csrbus_bresp;
  end

  assign csrbus_wvalid = (state == CSR_WRITE);
  assign csrbus_bready = (state == CSR_BRESP);
  assign csrbus_waddr  = csrbus_wvalid ? addr : '0;
  assign csrbus_wdata  = csrbus_wvalid ? data : '0;
  assign done          = (state == CSR_COMMIT);
  assign resp_err      = done && (bresp_q != 3'd0);

endmodule

// File: rtl/commit_buffer.sv
// In-order commit queue between execute and architectural state update.
// Optional retire counter enabled with COMMIT_BUFFER_RETIRE_COUNT_EN.
module commit_buffer
  import commit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$bits(commit_entry_t)-1:0] in_entry,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  input  logic                         datafifo_full,
  output logic [XLEN-1:0]              datafifo_addr,
  output logic [XLEN-1:0]              datafifo_val,
  output logic [1:0]                   datafifo_size,
  output logic                         datafifo_valid,
  output logic [5:0]                   exception_num,
  output logic [XLEN-1:0]              exception_val,
  output logic [XLEN-1:0]              exception_pc,
  output logic                         exception_valid,
  output logic [4:0]                   rd,
  output logic [XLEN-1:0]              rd_val,
  output logic                         rd_valid,
  output logic                         commit_valid,
  output logic                         pipeline_flush,
  output logic [XLEN-1:0]              pipeline_pc,
  output logic [31:0]                  active_rd,
  output logic [11:0]                  csrbus_waddr,
  output logic [XLEN-1:0]              csrbus_wdata,
  output logic                         csrbus_wvalid,
  input  logic                         csrbus_wready,
  input  logic [2:0]                   csrbus_bresp,
  input  logic                         csrbus_bvalid,
  output logic                         csrbus_bready
`ifdef COMMIT_BUFFER_RETIRE_COUNT_EN
  ,
  output logic [63:0]                  retire_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  commit_entry_t  mem [DEPTH];
  logic [PTR_W:0] rd_ptr, wr_ptr;
  logic           full, empty, push, pop;
  commit_entry_t  head;
  commit_kind_e   kind;
  logic           csr_done, csr_err, csr_retire;

  assign occupancy = CNT_W'(wr_ptr - rd_ptr);
  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (occupancy == CNT_W'(DEPTH));
  assign in_ready  = !full;

  // Masking the head keeps every data output at zero while empty.
  assign head = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_comb begin
    if (empty)                              kind = KIND_NODATA;
    else if (head.exception)                kind = KIND_EXCEPTION;
    else if (head.store && datafifo_full)   kind = KIND_WAIT_FIFO;
    else if (head.csr_write)                kind = KIND_WAIT_CSRW;
    else                                    kind = KIND_COMMIT;
  end

  commit_csr_writer #(.XLEN(XLEN)) u_csr_writer (
    .clk           (clk),
    .reset         (reset),
    .start         (kind == KIND_WAIT_CSRW),
    .addr          (head.csr_addr),
    .data          (head.csr_wdata),
    .csrbus_wready (csrbus_wready),
    .csrbus_bresp  (csrbus_bresp),
    .csrbus_bvalid (csrbus_bvalid),
    .csrbus_waddr  (csrbus_waddr),
    .csrbus_wdata  (csrbus_wdata),
    .csrbus_wvalid (csrbus_wvalid),
    .csrbus_bready (csrbus_bready),
    .done          (csr_done),
    .resp_err      (csr_err)
  );

  assign csr_retire = csr_done && (kind == KIND_WAIT_CSRW);

  always_comb begin
    commit_valid    = (kind == KIND_COMMIT) || (kind == KIND_EXCEPTION) || csr_retire;
    exception_valid = (kind == KIND_EXCEPTION) || (csr_retire && csr_err);
    rd_valid        = (head.rd != 5'd0) &&
                      ((kind == KIND_COMMIT) || (csr_retire && !csr_err));
    datafifo_valid  = (kind == KIND_COMMIT) && head.store;
    pipeline_flush  = exception_valid || ((kind == KIND_COMMIT) && head.jump);
    pipeline_pc     = ((kind == KIND_COMMIT) && head.jump) ? head.jump_pc : '0;
    exception_num   = (csr_retire && csr_err) ? EXC_INVALID_INST : head.exc_num;
    exception_val   = (csr_retire && csr_err) ? '0 : head.exc_val;
  end

  assign exception_pc  = head.inst_pc;
  assign rd            = head.rd;
  assign rd_val        = head.rd_val;
  assign datafifo_addr = head.store_addr;
  assign datafifo_val  = head.store_val;
  assign datafifo_size = head.store_size;

  assign pop  = commit_valid;
  assign push = in_valid && in_ready && !pipeline_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (pipeline_flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= commit_entry_t'(in_entry);
  end

  // Pending destinations; the head drops out in the cycle it writes back.
  always_comb begin
    logic [PTR_W-1:0] slot;
    active_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr[PTR_W-1:0] + PTR_W'(i);
      if ((CNT_W'(i) < occupancy) && (mem[slot].rd != 5'd0) && !((i == 0) && rd_valid))
        active_rd[mem[slot].rd] = 1'b1;
    end
  end

`ifdef COMMIT_BUFFER_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                 retire_count <= '0;
    else if (commit_valid && !exception_valid) retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_commit_buffer.sv
// Bench for commit_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the retire rules.
module tb_commit_buffer;
  import commit_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic reset;
  commit_entry_t in_entry;
  logic in_valid, in_ready;
  logic [2:0] occupancy;
  logic datafifo_full;
  logic [XLEN-1:0] datafifo_addr, datafifo_val;
  logic [1:0] datafifo_size;
  logic datafifo_valid;
  logic [5:0] exception_num;
  logic [XLEN-1:0] exception_val, exception_pc;
  logic exception_valid;
  logic [4:0] rd;
  logic [XLEN-1:0] rd_val;
  logic rd_valid, commit_valid, pipeline_flush;
  logic [XLEN-1:0] pipeline_pc;
  logic [31:0] active_rd;
  logic [11:0] csrbus_waddr;
  logic [XLEN-1:0] csrbus_wdata;
  logic csrbus_wvalid, csrbus_wready, csrbus_bvalid, csrbus_bready;
  logic [2:0] csrbus_bresp;
`ifdef COMMIT_BUFFER_RETIRE_COUNT_EN
  logic [63:0] retire_count;
`endif

  always #5 clk = ~clk;

  commit_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_entry(in_entry), .in_valid(in_valid),
    .in_ready(in_ready), .occupancy(occupancy), .datafifo_full(datafifo_full),
    .datafifo_addr(datafifo_addr), .datafifo_val(datafifo_val),
    .datafifo_size(datafifo_size), .datafifo_valid(datafifo_valid),
    .exception_num(exception_num), .exception_val(exception_val),
    .exception_pc(exception_pc), .exception_valid(exception_valid),
    .rd(rd), .rd_val(rd_val), .rd_valid(rd_valid), .commit_valid(commit_valid),
    .pipeline_flush(pipeline_flush), .pipeline_pc(pipeline_pc),
    .active_rd(active_rd), .csrbus_waddr(csrbus_waddr),
    .csrbus_wdata(csrbus_wdata), .csrbus_wvalid(csrbus_wvalid),
    .csrbus_wready(csrbus_wready), .csrbus_bresp(csrbus_bresp),
    .csrbus_bvalid(csrbus_bvalid), .csrbus_bready(csrbus_bready)
`ifdef COMMIT_BUFFER_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the queue contents in program order.
  commit_entry_t q[$];
  logic exp_csr_commit = 1'b0;
  logic exp_csr_err = 1'b0;
  logic [63:0] exp_retire = 64'd0;

  logic e_commit, e_rd_valid, e_df_valid, e_exc_valid, e_flush, e_ready;
  logic [XLEN-1:0] e_pc, e_exc_val, e_exc_pc;
  logic [5:0] e_exc_num;
  logic [31:0] e_active;
  logic [2:0] e_occ;
  commit_entry_t e_head;

  function automatic void model_eval();
    commit_entry_t h;
    e_commit = 0; e_rd_valid = 0; e_df_valid = 0; e_exc_valid = 0; e_flush = 0;
    e_pc = '0;
    e_occ = 3'(q.size());
    e_ready = (q.size() < DEPTH);
    h = (q.size() == 0) ? '0 : q[0];
    e_head = h;
    e_exc_pc = h.inst_pc; e_exc_num = h.exc_num; e_exc_val = h.exc_val;
    if (q.size() != 0) begin
      if (h.exception) begin
        e_commit = 1; e_exc_valid = 1; e_flush = 1;
      end else if (h.store && datafifo_full) begin
        e_commit = 0;
      end else if (h.csr_write) begin
        if (exp_csr_commit) begin
          e_commit = 1;
          if (exp_csr_err) begin
            e_exc_valid = 1; e_flush = 1; e_exc_num = 6'd2; e_exc_val = '0;
          end else e_rd_valid = (h.rd != 0);
        end
      end else begin
        e_commit = 1; e_rd_valid = (h.rd != 0); e_df_valid = h.store;
        e_flush = h.jump; e_pc = h.jump ? h.jump_pc : '0;
      end
    end
    e_active = '0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].rd != 0 && !(i == 0 && e_rd_valid)) e_active[q[i].rd] = 1'b1;
  endfunction

  function automatic void model_advance();
    if (e_commit && !e_exc_valid) exp_retire = exp_retire + 64'd1;
    if (e_flush) q.delete();
    else begin
      if (e_commit) void'(q.pop_front());
      if (in_valid && e_ready) q.push_back(in_entry);
    end
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(negedge clk);
  endtask

  function automatic commit_entry_t mk(input logic [4:0] r, input logic j,
                                       input logic st, input logic csr, input logic ex);
    commit_entry_t e;
    e.rd = r; e.rd_val = $urandom; e.inst_pc = $urandom;
    e.jump = j; e.jump_pc = $urandom;
    e.exception = ex; e.exc_num = 6'($urandom); e.exc_val = $urandom;
    e.store = st; e.store_addr = $urandom; e.store_val = $urandom;
    e.store_size = 2'($urandom);
    e.csr_write = csr; e.csr_addr = 12'($urandom); e.csr_wdata = $urandom;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1; in_valid = 0; in_entry = '0; datafifo_full = 0;
    csrbus_wready = 0; csrbus_bvalid = 0; csrbus_bresp = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    q.delete(); exp_retire = 0;
    settle();
    vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL reset occupancy got %0d want 0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    vectors++; if ({commit_valid, rd_valid, datafifo_valid, exception_valid, pipeline_flush, csrbus_wvalid, csrbus_bready} !== 7'd0) begin
      miscompares++; $display("FAIL reset valids got %b want 0", {commit_valid, rd_valid, datafifo_valid, exception_valid, pipeline_flush, csrbus_wvalid, csrbus_bready}); end
    vectors++; if ({active_rd, exception_pc, rd_val, datafifo_addr} !== '0) begin
      miscompares++; $display("FAIL reset data got %h want 0", {active_rd, exception_pc, rd_val, datafifo_addr}); end
`ifdef COMMIT_BUFFER_RETIRE_COUNT_EN
    vectors++; if (retire_count !== 64'd0) begin miscompares++; $display("FAIL reset retire_count got %0d want 0", retire_count); end
`endif
    advance();
  endtask

  task automatic test_fill_stall();
    datafifo_full = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_entry = (k == 0) ? mk(5'd0, 0, 1, 0, 0) : mk(5'(k + 10), 0, 0, 0, 0);
      settle();
      vectors++; if (in_ready !== e_ready || occupancy !== e_occ) begin
        miscompares++; $display("FAIL fill ready/occ got %b/%0d want %b/%0d", in_ready, occupancy, e_ready, e_occ); end
      vectors++; if (commit_valid !== 1'b0 || datafifo_valid !== 1'b0) begin
        miscompares++; $display("FAIL fill stalled commit/df got %b/%b want 0/0", commit_valid, datafifo_valid); end
      if (k == 4) begin
        vectors++; if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
          miscompares++; $display("FAIL fill full got ready=%b occ=%0d want ready=0 occ=4", in_ready, occupancy); end
      end
      advance();
    end
    in_valid = 0; datafifo_full = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      vectors++; if (commit_valid !== 1'b1 || rd !== e_head.rd || rd_valid !== e_rd_valid) begin
        miscompares++; $display("FAIL drain[%0d] commit/rd/rd_valid got %b/%0d/%b want 1/%0d/%b", k, commit_valid, rd, rd_valid, e_head.rd, e_rd_valid); end
      vectors++; if (datafifo_valid !== (k == 0) || occupancy !== 3'(4 - k)) begin
        miscompares++; $display("FAIL drain[%0d] df/occ got %b/%0d want %b/%0d", k, datafifo_valid, occupancy, (k == 0), 4 - k); end
      advance();
    end
  endtask

  task automatic test_jump_flush();
    commit_entry_t j;
    datafifo_full = 1;
    j = mk(5'd6, 1, 0, 0, 0); j.jump_pc = 32'h100;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      case (k)
        0: in_entry = mk(5'd0, 0, 1, 0, 0);
        1: in_entry = j;
        default: in_entry = mk(5'(k + 1), 0, 0, 0, 0);
      endcase
      settle(); advance();
    end
    in_valid = 0; datafifo_full = 0;
    settle(); advance();
    in_valid = 1; in_entry = mk(5'd9, 0, 0, 0, 0);
    settle();
    vectors++; if (pipeline_flush !== 1'b1 || pipeline_pc !== 32'h100) begin
      miscompares++; $display("FAIL jump flush/pc got %b/%h want 1/00000100", pipeline_flush, pipeline_pc); end
    vectors++; if (occupancy !== 3'd3 || commit_valid !== 1'b1 || rd_valid !== 1'b1 || rd !== 5'd6) begin
      miscompares++; $display("FAIL jump occ/commit/rd got %0d/%b/%0d want 3/1/6", occupancy, commit_valid, rd); end
    advance();
    in_valid = 0;
    settle();
    vectors++; if (occupancy !== 3'd0 || commit_valid !== 1'b0 || active_rd !== 32'd0) begin
      miscompares++; $display("FAIL jump after-flush occ/commit/active got %0d/%b/%h want 0/0/0", occupancy, commit_valid, active_rd); end
    advance();
  endtask

  task automatic test_csr(input logic [2:0] resp);
    commit_entry_t e;
    e = mk((resp == 0) ? 5'd4 : 5'd9, 0, 0, 1, 0);
    e.csr_addr = 12'h300;
    in_valid = 1; in_entry = e; settle(); advance();
    in_valid = 0; csrbus_wready = 0; settle();
    vectors++; if (csrbus_wvalid !== 1'b0 || commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL csr idle wvalid/commit got %b/%b want 0/0", csrbus_wvalid, commit_valid); end
    advance();
    settle();
    vectors++; if (csrbus_wvalid !== 1'b1 || csrbus_waddr !== 12'h300 || csrbus_wdata !== e.csr_wdata || csrbus_bready !== 1'b0) begin
      miscompares++; $display("FAIL csr write wvalid/waddr/wdata got %b/%h/%h want 1/300/%h", csrbus_wvalid, csrbus_waddr, csrbus_wdata, e.csr_wdata); end
    advance();
    csrbus_wready = 1; settle();
    vectors++; if (csrbus_wvalid !== 1'b1) begin miscompares++; $display("FAIL csr write hold wvalid got %b want 1", csrbus_wvalid); end
    advance();
    csrbus_wready = 0; settle();
    vectors++; if (csrbus_bready !== 1'b1 || csrbus_wvalid !== 1'b0 || commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL csr bresp bready/wvalid/commit got %b/%b/%b want 1/0/0", csrbus_bready, csrbus_wvalid, commit_valid); end
    advance();
    csrbus_bvalid = 1; csrbus_bresp = resp; settle();
    vectors++; if (csrbus_bready !== 1'b1 || commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL csr bvalid bready/commit got %b/%b want 1/0", csrbus_bready, commit_valid); end
    advance();
    csrbus_bvalid = 0; csrbus_bresp = 0;
    exp_csr_commit = 1; exp_csr_err = (resp != 0);
    settle();
    vectors++; if (commit_valid !== 1'b1 || exception_valid !== (resp != 0) || rd_valid !== (resp == 0) || pipeline_flush !== (resp != 0)) begin
      miscompares++; $display("FAIL csr commit commit/exc/rd_valid/flush got %b/%b/%b/%b want 1/%b/%b/%b", commit_valid, exception_valid, rd_valid, pipeline_flush, resp != 0, resp == 0, resp != 0); end
    if (resp != 0) begin
      vectors++; if (exception_num !== 6'd2 || exception_val !== '0 || exception_pc !== e.inst_pc) begin
        miscompares++; $display("FAIL csr exc num/val/pc got %0d/%h/%h want 2/0/%h", exception_num, exception_val, exception_pc, e.inst_pc); end
    end
    vectors++; if (csrbus_wvalid !== 1'b0 || csrbus_bready !== 1'b0) begin
      miscompares++; $display("FAIL csr commit handshake got %b/%b want 0/0", csrbus_wvalid, csrbus_bready); end
    advance();
    exp_csr_commit = 0; exp_csr_err = 0;
    settle();
    vectors++; if (occupancy !== 3'd0 || commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL csr after occ/commit got %0d/%b want 0/0", occupancy, commit_valid); end
    advance();
  endtask

  task automatic test_active_rd();
    logic [4:0] rds [4];
    rds = '{5'd0, 5'd5, 5'd7, 5'd0};
    datafifo_full = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_entry = mk(rds[k], 0, (k == 0), 0, 0);
      settle(); advance();
    end
    in_valid = 0; settle();
    vectors++; if (active_rd !== 32'h0000_00A0) begin miscompares++; $display("FAIL active pending got %h want 000000a0", active_rd); end
    advance();
    datafifo_full = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      vectors++; if (active_rd !== e_active || rd_valid !== (rds[k] != 0) || commit_valid !== 1'b1) begin
        miscompares++; $display("FAIL active retire[%0d] active/rd_valid/commit got %h/%b/%b want %h/%b/1", k, active_rd, rd_valid, commit_valid, e_active, rds[k] != 0); end
      if (k == 1) begin
        vectors++; if (active_rd !== 32'h0000_0080) begin miscompares++; $display("FAIL active head-excluded got %h want 00000080", active_rd); end
      end
      advance();
    end
  endtask

  task automatic test_reset_in_bresp();
    csrbus_wready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_entry = (k == 0) ? mk(5'd3, 0, 0, 1, 0) : mk(5'(k + 20), 0, 0, 0, 0);
      settle(); advance();
    end
    in_valid = 0; csrbus_wready = 0; settle();
    vectors++; if (csrbus_bready !== 1'b1 || occupancy !== 3'd3) begin
      miscompares++; $display("FAIL rstbresp before bready/occ got %b/%0d want 1/3", csrbus_bready, occupancy); end
    reset = 1; csrbus_bvalid = 1; csrbus_bresp = 3'd2;
    @(negedge clk);
    reset = 0; q.delete(); exp_retire = 0;
    settle();
    vectors++; if (occupancy !== 3'd0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstbresp occ/ready got %0d/%b want 0/1", occupancy, in_ready); end
    vectors++; if ({commit_valid, rd_valid, exception_valid, pipeline_flush, csrbus_wvalid, csrbus_bready, active_rd} !== '0) begin
      miscompares++; $display("FAIL rstbresp outputs got %h want 0", {commit_valid, rd_valid, exception_valid, pipeline_flush, csrbus_wvalid, csrbus_bready, active_rd}); end
    advance();
    csrbus_bvalid = 0; csrbus_bresp = 0;
    settle();
    vectors++; if (csrbus_bready !== 1'b0 || commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL rstbresp idle bready/commit got %b/%b want 0/0", csrbus_bready, commit_valid); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      datafifo_full = ($urandom_range(0, 1) == 0);
      in_entry = mk(5'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                    1'b0, ($urandom_range(0, 11) == 0));
      settle();
      vectors++; if ({commit_valid, rd_valid, datafifo_valid, exception_valid, pipeline_flush} !== {e_commit, e_rd_valid, e_df_valid, e_exc_valid, e_flush}) begin
        miscompares++; $display("FAIL rand[%0d] commit/rd/df/exc/flush got %b want %b", n, {commit_valid, rd_valid, datafifo_valid, exception_valid, pipeline_flush}, {e_commit, e_rd_valid, e_df_valid, e_exc_valid, e_flush}); end
      vectors++; if (in_ready !== e_ready || occupancy !== e_occ || active_rd !== e_active) begin
        miscompares++; $display("FAIL rand[%0d] ready/occ/active got %b/%0d/%h want %b/%0d/%h", n, in_ready, occupancy, active_rd, e_ready, e_occ, e_active); end
      vectors++; if (exception_pc !== e_exc_pc || csrbus_wvalid !== 1'b0) begin
        miscompares++; $display("FAIL rand[%0d] exc_pc/wvalid got %h/%b want %h/0", n, exception_pc, csrbus_wvalid, e_exc_pc); end
      if (e_rd_valid) begin
        vectors++; if (rd !== e_head.rd || rd_val !== e_head.rd_val) begin
          miscompares++; $display("FAIL rand[%0d] rd/rd_val got %0d/%h want %0d/%h", n, rd, rd_val, e_head.rd, e_head.rd_val); end
      end
      if (e_df_valid) begin
        vectors++; if (datafifo_addr !== e_head.store_addr || datafifo_val !== e_head.store_val || datafifo_size !== e_head.store_size) begin
          miscompares++; $display("FAIL rand[%0d] store got %h/%h/%0d want %h/%h/%0d", n, datafifo_addr, datafifo_val, datafifo_size, e_head.store_addr, e_head.store_val, e_head.store_size); end
      end
      if (e_exc_valid) begin
        vectors++; if (exception_num !== e_exc_num || exception_val !== e_exc_val) begin
          miscompares++; $display("FAIL rand[%0d] exc num/val got %0d/%h want %0d/%h", n, exception_num, exception_val, e_exc_num, e_exc_val); end
      end
      if (e_flush && !e_exc_valid) begin
        vectors++; if (pipeline_pc !== e_pc) begin
          miscompares++; $display("FAIL rand[%0d] pipeline_pc got %h want %h", n, pipeline_pc, e_pc); end
      end
      if (e_occ == 3'd0) begin
        vectors++; if ({rd, rd_val, datafifo_addr, datafifo_val, exception_val} !== '0) begin
          miscompares++; $display("FAIL rand[%0d] empty data got %h want 0", n, {rd, rd_val, datafifo_addr, datafifo_val, exception_val}); end
      end
      advance();
    end
`ifdef COMMIT_BUFFER_RETIRE_COUNT_EN
    in_valid = 0; settle();
    vectors++; if (retire_count !== exp_retire) begin
      miscompares++; $display("FAIL retire_count got %0d want %0d", retire_count, exp_retire); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_jump_flush();
    test_csr(3'd2);
    test_csr(3'd0);
    test_active_rd();
    test_reset_in_bresp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
